// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single registered ALU.
// One operation in flight: grant, issue operands, wait ALU_LAT cycles, return the tagged result.
module alu_arbiter #(
   parameter int DATA_W  = 4,
   parameter int OP_W    = 2,
   parameter int OUT_W   = 8,
   parameter int ALU_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req0,
   input  logic [DATA_W-1:0] a0,
   input  logic [DATA_W-1:0] b0,
   input  logic [OP_W-1:0]   op0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] b1,
   input  logic [OP_W-1:0]   op1,
   output logic              gnt1,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [OUT_W-1:0]  alu_out,
   output logic [OUT_W-1:0]  res,
   output logic              res_id,
   output logic              res_vld,
   output logic              busy
);

   localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;
   logic               id_q, id_d;
   logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [OP_W-1:0]    alu_op_q, alu_op_d;
   logic [OUT_W-1:0]   res_q, res_d;
   logic               res_id_q, res_id_d;
   logic               res_vld_q, res_vld_d;
   logic               busy_q, busy_d;
   logic               pick0, pick1;

   // Round-robin: on contention the requester that did not win last time goes first.
   assign pick0 = req0 & (~req1 | last_q);
   assign pick1 = req1 & (~req0 | ~last_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      id_d      = id_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      res_d     = res_q;
      res_id_d  = res_id_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      res_vld_d = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (pick0) begin
               alu_a_d  = a0;
               alu_b_d  = b0;
               alu_op_d = op0;
               id_d     = 1'b0;
               last_d   = 1'b0;
               gnt0_d   = 1'b1;
               state_d  = ISSUE;
            end else if (pick1) begin
               alu_a_d  = a1;
               alu_b_d  = b1;
               alu_op_d = op1;
               id_d     = 1'b1;
               last_d   = 1'b1;
               gnt1_d   = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_W'(ALU_LAT);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               res_d     = alu_out;
               res_id_d  = id_q;
               res_vld_d = 1'b1;
               cnt_d     = '0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         res_q     <= '0;
         res_id_q  <= 1'b0;
         res_vld_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         id_q      <= id_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         res_q     <= res_d;
         res_id_q  <= res_id_d;
         res_vld_q <= res_vld_d;
         busy_q    <= busy_d;
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_op  = alu_op_q;
   assign res     = res_q;
   assign res_id  = res_id_q;
   assign res_vld = res_vld_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios on ALU_LAT=1 and ALU_LAT=3 instances,
// plus a randomized run checked against a transaction-level arbitration model.
module tb_alu_arbiter;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   int         checks = 0;
   int         failures = 0;

   // ALU_LAT=1 instance
   logic       req0 = 0, req1 = 0, gnt0, gnt1, res_id, res_vld, busy;
   logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, alu_a, alu_b;
   logic [1:0] op0 = 0, op1 = 0, alu_op;
   logic [7:0] alu_out, res;
   // ALU_LAT=3 instance
   logic       x_req0 = 0, x_req1 = 0, x_gnt0, x_gnt1, x_res_id, x_res_vld, x_busy;
   logic [3:0] x_a0 = 0, x_b0 = 0, x_a1 = 0, x_b1 = 0, x_alu_a, x_alu_b;
   logic [1:0] x_op0 = 0, x_op1 = 0, x_alu_op;
   logic [7:0] x_alu_out, x_res, x_p1, x_p2;

   always #5 CLK = ~CLK;

   // ALU stand-ins: concatenate operands so the result exposes the routing.
   always @(posedge CLK) alu_out <= {alu_a, alu_b};
   always @(posedge CLK) begin
      x_p1      <= {x_alu_a, x_alu_b};
      x_p2      <= x_p1;
      x_alu_out <= x_p2;
   end

   alu_arbiter #(.DATA_W(4), .OP_W(2), .OUT_W(8), .ALU_LAT(1)) u_lat1 (
      .CLK(CLK), .RST(RST),
      .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0),
      .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
      .res(res), .res_id(res_id), .res_vld(res_vld), .busy(busy));

   alu_arbiter #(.DATA_W(4), .OP_W(2), .OUT_W(8), .ALU_LAT(3)) u_lat3 (
      .CLK(CLK), .RST(RST),
      .req0(x_req0), .a0(x_a0), .b0(x_b0), .op0(x_op0), .gnt0(x_gnt0),
      .req1(x_req1), .a1(x_a1), .b1(x_b1), .op1(x_op1), .gnt1(x_gnt1),
      .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_op(x_alu_op), .alu_out(x_alu_out),
      .res(x_res), .res_id(x_res_id), .res_vld(x_res_vld), .busy(x_busy));

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      req0 = 0; req1 = 0; x_req0 = 0; x_req1 = 0;
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
   endtask

   task automatic test_reset;
      RST = 1'b0;
      #2;
      checks++; if ({gnt0, gnt1, res_vld, busy} !== 4'b0) begin failures++; $display("FAIL reset_ctl got=%b want=0000", {gnt0, gnt1, res_vld, busy}); end
      checks++; if ({alu_a, alu_b, alu_op} !== 10'h0) begin failures++; $display("FAIL reset_alu got=%h want=0", {alu_a, alu_b, alu_op}); end
      checks++; if ({res, res_id} !== 9'h0) begin failures++; $display("FAIL reset_res got=%h want=0", {res, res_id}); end
      checks++; if ({x_gnt0, x_gnt1, x_res_vld, x_busy, x_res} !== 12'h0) begin failures++; $display("FAIL reset_lat3 got=%h want=0", {x_gnt0, x_gnt1, x_res_vld, x_busy, x_res}); end
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
   endtask

   task automatic test_single;
      req0 = 1; a0 = 4'd3; b0 = 4'd5; op0 = 2'd2;
      tick;  // cycle 1
      checks++; if ({gnt0, gnt1, busy} !== 3'b101) begin failures++; $display("FAIL single_gnt got=%b want=101", {gnt0, gnt1, busy}); end
      checks++; if ({alu_a, alu_b, alu_op} !== {4'd3, 4'd5, 2'd2}) begin failures++; $display("FAIL single_alu got=%h want=%h", {alu_a, alu_b, alu_op}, {4'd3, 4'd5, 2'd2}); end
      req0 = 0;
      tick;  // cycle 2
      checks++; if ({gnt0, res_vld, busy} !== 3'b001) begin failures++; $display("FAIL single_c2 got=%b want=001", {gnt0, res_vld, busy}); end
      tick;  // cycle 3
      checks++; if ({res_vld, busy, res_id} !== 3'b110) begin failures++; $display("FAIL single_vld got=%b want=110", {res_vld, busy, res_id}); end
      checks++; if (res !== 8'h35) begin failures++; $display("FAIL single_res got=%h want=35", res); end
      tick;  // cycle 4
      checks++; if ({res_vld, busy} !== 2'b00) begin failures++; $display("FAIL single_end got=%b want=00", {res_vld, busy}); end
   endtask

   task automatic test_simultaneous;
      do_reset;
      req0 = 1; a0 = 4'd1; b0 = 4'd2; op0 = 2'd1;
      req1 = 1; a1 = 4'd4; b1 = 4'd7; op1 = 2'd3;
      for (int c = 1; c <= 7; c++) begin
         tick;
         checks++; if (gnt0 && gnt1) begin failures++; $display("FAIL sim_overlap cycle=%0d got=11 want=not both", c); end
         checks++; if (gnt0 !== (c == 1) || gnt1 !== (c == 4)) begin failures++; $display("FAIL sim_gnt cycle=%0d got=%b%b", c, gnt0, gnt1); end
         checks++; if (res_vld !== (c == 3 || c == 6)) begin failures++; $display("FAIL sim_vld cycle=%0d got=%b", c, res_vld); end
         if (c == 1) req0 = 0;
         if (c == 4) req1 = 0;
         if (c == 3) begin
            checks++; if ({res, res_id} !== {8'h12, 1'b0}) begin failures++; $display("FAIL sim_res0 got=%h/%b want=12/0", res, res_id); end
         end
         if (c == 6) begin
            checks++; if ({res, res_id} !== {8'h47, 1'b1}) begin failures++; $display("FAIL sim_res1 got=%h/%b want=47/1", res, res_id); end
         end
      end
   endtask

   task automatic test_fairness;
      int ngnt = 0, nres = 0, last_vld = -1, want_id = 0;
      logic [8:0] expq[$];
      logic [8:0] e;
      do_reset;
      req0 = 1; a0 = 4'($urandom); b0 = 4'($urandom);
      req1 = 1; a1 = 4'($urandom); b1 = 4'($urandom);
      for (int c = 1; c <= 40 && nres < 6; c++) begin
         tick;
         checks++; if (gnt0 && gnt1) begin failures++; $display("FAIL fair_overlap cycle=%0d", c); end
         if (gnt0 || gnt1) begin
            checks++; if (gnt1 !== want_id[0]) begin failures++; $display("FAIL fair_order grant=%0d got=%b want=%0d", ngnt, gnt1, want_id); end
            expq.push_back(gnt1 ? {1'b1, a1, b1} : {1'b0, a0, b0});
            want_id ^= 1; ngnt++;
            if (gnt0) begin a0 = 4'($urandom); b0 = 4'($urandom); end
            else      begin a1 = 4'($urandom); b1 = 4'($urandom); end
            if (ngnt == 6) begin req0 = 0; req1 = 0; end
         end
         if (res_vld) begin
            if (last_vld >= 0) begin
               checks++; if (c - last_vld != 3) begin failures++; $display("FAIL fair_spacing got=%0d want=3", c - last_vld); end
            end
            e = (expq.size() > 0) ? expq.pop_front() : 9'h1XX;
            checks++; if ({res_id, res} !== e) begin failures++; $display("FAIL fair_res got=%h want=%h", {res_id, res}, e); end
            last_vld = c; nres++;
         end
      end
      checks++; if (ngnt != 6 || nres != 6) begin failures++; $display("FAIL fair_count got=%0d/%0d want=6/6", ngnt, nres); end
      req0 = 0; req1 = 0;
      tick;
   endtask

   task automatic test_lat3;
      do_reset;
      x_req1 = 1; x_a1 = 4'hF; x_b1 = 4'hF; x_op1 = 2'd1;
      tick;  // cycle 1
      checks++; if ({x_gnt0, x_gnt1} !== 2'b01) begin failures++; $display("FAIL lat3_gnt got=%b want=01", {x_gnt0, x_gnt1}); end
      x_req1 = 0;
      for (int c = 2; c <= 6; c++) begin
         tick;
         checks++; if (x_res_vld !== (c == 5)) begin failures++; $display("FAIL lat3_vld cycle=%0d got=%b", c, x_res_vld); end
         checks++; if (x_busy !== (c <= 5)) begin failures++; $display("FAIL lat3_busy cycle=%0d got=%b", c, x_busy); end
         if (c == 5) begin
            checks++; if ({x_res, x_res_id} !== {8'hFF, 1'b1}) begin failures++; $display("FAIL lat3_res got=%h/%b want=ff/1", x_res, x_res_id); end
         end
      end
   endtask

   task automatic test_reset_in_wait;
      do_reset;
      req0 = 1; a0 = 4'd10; b0 = 4'd11; op0 = 2'd1;
      tick;       // cycle 1: grant, pointer now at requester 0
      req0 = 0;
      tick;       // cycle 2: WAIT
      RST = 1'b0;
      #1;
      checks++; if ({busy, gnt0, gnt1, res_vld} !== 4'b0) begin failures++; $display("FAIL rstw_now got=%b want=0000", {busy, gnt0, gnt1, res_vld}); end
      checks++; if ({alu_a, alu_b, alu_op, res} !== 18'h0) begin failures++; $display("FAIL rstw_regs got=%h want=0", {alu_a, alu_b, alu_op, res}); end
      @(posedge CLK); #1 RST = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         checks++; if ({res_vld, busy} !== 2'b00) begin failures++; $display("FAIL rstw_quiet cycle=%0d got=%b want=00", c, {res_vld, busy}); end
      end
      req0 = 1; a0 = 4'd9; b0 = 4'd6; op0 = 2'd3;
      req1 = 1; a1 = 4'd2; b1 = 4'd8; op1 = 2'd0;
      tick;
      checks++; if ({gnt0, gnt1} !== 2'b10) begin failures++; $display("FAIL rstw_ptr got=%b want=10", {gnt0, gnt1}); end
      req0 = 0; req1 = 0;
      tick; tick;
      checks++; if ({res_vld, res, res_id} !== {1'b1, 8'h96, 1'b0}) begin failures++; $display("FAIL rstw_res got=%b/%h/%b want=1/96/0", res_vld, res, res_id); end
      tick;
   endtask

   task automatic test_idle;
      for (int c = 0; c < 10; c++) begin
         a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
         a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
         tick;
         checks++; if ({busy, gnt0, gnt1, res_vld} !== 4'b0) begin failures++; $display("FAIL idle_ctl cycle=%0d got=%b want=0000", c, {busy, gnt0, gnt1, res_vld}); end
         checks++; if ({alu_a, alu_b, alu_op, res} !== {4'd9, 4'd6, 2'd3, 8'h96}) begin failures++; $display("FAIL idle_hold cycle=%0d got=%h", c, {alu_a, alu_b, alu_op, res}); end
      end
   endtask

   // Transaction model: the server is free when nothing is outstanding or a result is
   // being returned this cycle; a free server grants the next cycle by round-robin.
   task automatic test_random;
      int last_m = 1, due = 0;
      bit inflight = 0, pg0 = 0, pg1 = 0, rv_exp, free;
      logic [3:0] pa = 0, pb = 0;
      logic [1:0] pop = 0;
      logic [8:0] exp_r = 0;
      do_reset;
      for (int c = 0; c < 500; c++) begin
         tick;
         if (pg0 || pg1) begin
            inflight = 1; due = c + 2; exp_r = {pg1, pa, pb}; last_m = pg1 ? 1 : 0;
            checks++; if ({alu_a, alu_b, alu_op} !== {pa, pb, pop}) begin failures++; $display("FAIL rnd_alu cycle=%0d got=%h want=%h", c, {alu_a, alu_b, alu_op}, {pa, pb, pop}); end
         end
         rv_exp = inflight && (due == c);
         checks++; if ({gnt0, gnt1} !== {pg0, pg1}) begin failures++; $display("FAIL rnd_gnt cycle=%0d got=%b%b want=%b%b", c, gnt0, gnt1, pg0, pg1); end
         checks++; if ({res_vld, busy} !== {rv_exp, inflight}) begin failures++; $display("FAIL rnd_vld_busy cycle=%0d got=%b%b want=%b%b", c, res_vld, busy, rv_exp, inflight); end
         if (rv_exp) begin
            checks++; if ({res_id, res} !== exp_r) begin failures++; $display("FAIL rnd_res cycle=%0d got=%h want=%h", c, {res_id, res}, exp_r); end
         end
         free = !inflight || rv_exp;
         if (rv_exp) inflight = 0;
         if (pg0) req0 = ($urandom_range(1) == 1);
         else if (!req0) req0 = ($urandom_range(99) < 30);
         if (pg0 || (req0 && !gnt0 && !pg0 && $urandom_range(0) == 0 && !free && 0)) ;
         if (pg1) req1 = ($urandom_range(1) == 1);
         else if (!req1) req1 = ($urandom_range(99) < 30);
         if (pg0 || !req0) begin a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom); end
         if (pg1 || !req1) begin a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom); end
         pg0 = 0; pg1 = 0;
         if (free) begin
            if (req0 && req1) begin pg0 = (last_m == 1); pg1 = (last_m == 0); end
            else begin pg0 = req0; pg1 = req1; end
         end
         if (pg0) begin pa = a0; pb = b0; pop = op0; end
         if (pg1) begin pa = a1; pb = b1; pop = op1; end
      end
      req0 = 0; req1 = 0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_simultaneous;
      test_fairness;
      test_lat3;
      test_reset_in_wait;
      test_idle;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
